// File: rtl/traffic_light_ctrl_p.sv
// traffic_light_ctrl_p
// Two-road traffic light controller with per-road minimum/maximum green
// times, latched vehicle requests that can end a green early, a flashing
// night mode and an internal tick prescaler.
//
// Ports:
//   CLK100MHZ  in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   req_a      in   level request from road A (debounced, synchronised)
//   req_b      in   level request from road B (debounced, synchronised)
//   flash      in   night-mode request, level, honoured in the RED states
//   light_a    out  road A lights {red,yellow,green}, 000 when flash is dark
//   light_b    out  road B lights {red,yellow,green}, 000 when flash is dark
//   timer      out  ticks since the current state was entered, starts at 1
//   state      out  current state code
//   tick       out  one-cycle timer tick pulse
module traffic_light_ctrl_p #(
    parameter int TICK_DIV    = 100_000_000,
    parameter int TW          = 4,
    parameter int MIN_GREEN_A = 6,
    parameter int MAX_GREEN_A = 9,
    parameter int MIN_GREEN_B = 4,
    parameter int MAX_GREEN_B = 6,
    parameter int YELLOW_T    = 2,
    parameter int ALLRED_T    = 2
) (
    input  logic          CLK100MHZ,
    input  logic          reset,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          flash,
    output logic [2:0]    light_a,
    output logic [2:0]    light_b,
    output logic [TW-1:0] timer,
    output logic [2:0]    state,
    output logic          tick
);

    typedef enum logic [2:0] {
        GREEN_A  = 3'd0,
        YELLOW_A = 3'd1,
        RED_A    = 3'd2,
        GREEN_B  = 3'd3,
        YELLOW_B = 3'd4,
        RED_B    = 3'd5,
        FLASH    = 3'd6
    } state_t;

    localparam int PW = $clog2(TICK_DIV);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] T_SAT      = {TW{1'b1}};
    localparam logic [TW-1:0] MIN_A_T    = TW'(MIN_GREEN_A);
    localparam logic [TW-1:0] MAX_A_T    = TW'(MAX_GREEN_A);
    localparam logic [TW-1:0] MIN_B_T    = TW'(MIN_GREEN_B);
    localparam logic [TW-1:0] MAX_B_T    = TW'(MAX_GREEN_B);
    localparam logic [TW-1:0] YEL_T      = TW'(YELLOW_T);
    localparam logic [TW-1:0] RED_T      = TW'(ALLRED_T);

    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;
    localparam logic [2:0] LT_OFF = 3'b000;

    // The state register is a raw 3-bit code rather than state_t so that the
    // illegal code 7 is representable and can be recovered from.
    logic [2:0]    state_r;
    logic [2:0]    next_state_s;
    logic [TW-1:0] timer_r;
    logic [PW-1:0] presc_r;
    logic          pend_a_r;
    logic          pend_b_r;
    logic          blink_r;
    logic          tick_s;

    assign tick_s = (presc_r == PRESC_LAST);

    // Next-state decision; green states check MAX expiry before early exit.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            GREEN_A: begin
                if (tick_s && (timer_r >= MAX_A_T)) begin
                    next_state_s = YELLOW_A;
                end else if ((timer_r >= MIN_A_T) && pend_b_r && !req_a) begin
                    next_state_s = YELLOW_A;
                end else begin
                    next_state_s = GREEN_A;
                end
            end
            YELLOW_A: begin
                if (tick_s && (timer_r >= YEL_T)) begin
                    next_state_s = RED_A;
                end else begin
                    next_state_s = YELLOW_A;
                end
            end
            RED_A: begin
                if (tick_s && (timer_r >= RED_T)) begin
                    next_state_s = flash ? FLASH : GREEN_B;
                end else begin
                    next_state_s = RED_A;
                end
            end
            GREEN_B: begin
                if (tick_s && (timer_r >= MAX_B_T)) begin
                    next_state_s = YELLOW_B;
                end else if ((timer_r >= MIN_B_T) && pend_a_r && !req_b) begin
                    next_state_s = YELLOW_B;
                end else begin
                    next_state_s = GREEN_B;
                end
            end
            YELLOW_B: begin
                if (tick_s && (timer_r >= YEL_T)) begin
                    next_state_s = RED_B;
                end else begin
                    next_state_s = YELLOW_B;
                end
            end
            RED_B: begin
                if (tick_s && (timer_r >= RED_T)) begin
                    next_state_s = flash ? FLASH : GREEN_A;
                end else begin
                    next_state_s = RED_B;
                end
            end
            FLASH: begin
                if (tick_s && !flash) begin
                    next_state_s = RED_B;
                end else begin
                    next_state_s = FLASH;
                end
            end
            default: begin
                next_state_s = RED_B;
            end
        endcase
    end

    // State, timer, prescaler, request latches and blink bit.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_r  <= RED_B;
            timer_r  <= TW'(1);
            presc_r  <= PW'(0);
            pend_a_r <= 1'b0;
            pend_b_r <= 1'b0;
            blink_r  <= 1'b1;
        end else begin
            state_r <= next_state_s;

            if (tick_s) begin
                presc_r <= PW'(0);
            end else begin
                presc_r <= presc_r + PW'(1);
            end

            // Timer restarts at 1 on any state change and saturates.
            if (next_state_s != state_r) begin
                timer_r <= TW'(1);
            end else if (tick_s && (timer_r != T_SAT)) begin
                timer_r <= timer_r + TW'(1);
            end else begin
                timer_r <= timer_r;
            end

            // A request is only remembered while its road is not green.
            if ((next_state_s == GREEN_A) && (state_r != GREEN_A)) begin
                pend_a_r <= 1'b0;
            end else if (req_a && (state_r != GREEN_A)) begin
                pend_a_r <= 1'b1;
            end else begin
                pend_a_r <= pend_a_r;
            end

            if ((next_state_s == GREEN_B) && (state_r != GREEN_B)) begin
                pend_b_r <= 1'b0;
            end else if (req_b && (state_r != GREEN_B)) begin
                pend_b_r <= 1'b1;
            end else begin
                pend_b_r <= pend_b_r;
            end

            if ((next_state_s == FLASH) && (state_r != FLASH)) begin
                blink_r <= 1'b1;
            end else if ((state_r == FLASH) && tick_s) begin
                blink_r <= ~blink_r;
            end else begin
                blink_r <= blink_r;
            end
        end
    end

    // Light decode from the state register; unknown codes show all red.
    always_comb begin
        light_a = LT_RED;
        light_b = LT_RED;
        case (state_r)
            GREEN_A:  begin light_a = LT_GRN; light_b = LT_RED; end
            YELLOW_A: begin light_a = LT_YEL; light_b = LT_RED; end
            RED_A:    begin light_a = LT_RED; light_b = LT_RED; end
            GREEN_B:  begin light_a = LT_RED; light_b = LT_GRN; end
            YELLOW_B: begin light_a = LT_RED; light_b = LT_YEL; end
            RED_B:    begin light_a = LT_RED; light_b = LT_RED; end
            FLASH: begin
                if (blink_r) begin
                    light_a = LT_YEL;
                    light_b = LT_RED;
                end else begin
                    light_a = LT_OFF;
                    light_b = LT_OFF;
                end
            end
            default:  begin light_a = LT_RED; light_b = LT_RED; end
        endcase
    end

    assign state = state_r;
    assign timer = timer_r;
    assign tick  = tick_s;

endmodule

// File: tb/tb_traffic_light_ctrl_p.sv
module tb_traffic_light_ctrl_p;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_a;
    logic       req_b;
    logic       flash;
    logic [2:0] light_a;
    logic [2:0] light_b;
    logic [3:0] timer;
    logic [2:0] state;
    logic       tick;

    logic       reset2;
    logic       flash2;
    logic [2:0] light_a2;
    logic [2:0] light_b2;
    logic [1:0] timer2;
    logic [2:0] state2;
    logic       tick2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    traffic_light_ctrl_p #(
        .TICK_DIV(4), .TW(4), .MIN_GREEN_A(3), .MAX_GREEN_A(6),
        .MIN_GREEN_B(2), .MAX_GREEN_B(4), .YELLOW_T(2), .ALLRED_T(1)
    ) u_dut (
        .CLK100MHZ(clk), .reset(reset), .req_a(req_a), .req_b(req_b),
        .flash(flash), .light_a(light_a), .light_b(light_b),
        .timer(timer), .state(state), .tick(tick)
    );

    traffic_light_ctrl_p #(
        .TICK_DIV(2), .TW(2), .MIN_GREEN_A(2), .MAX_GREEN_A(3),
        .MIN_GREEN_B(1), .MAX_GREEN_B(2), .YELLOW_T(1), .ALLRED_T(1)
    ) u_sat (
        .CLK100MHZ(clk), .reset(reset2), .req_a(1'b0), .req_b(1'b0),
        .flash(flash2), .light_a(light_a2), .light_b(light_b2),
        .timer(timer2), .state(state2), .tick(tick2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset  = 1'b1;
        req_a  = 1'b0;
        req_b  = 1'b0;
        flash  = 1'b0;
        reset2 = 1'b1;
        flash2 = 1'b1;

        // 1. reset and free run
        cyc(1);
        chk("rst_state", state, 3'd5);
        chk("rst_la", light_a, 3'b100);
        chk("rst_lb", light_b, 3'b100);
        chk("rst_timer", timer, 4'd1);
        chk("rst_tick", tick, 1'b0);
        reset = 1'b0;
        cyc(3);
        chk("first_tick", tick, 1'b1);
        chk("first_tick_state", state, 3'd5);
        cyc(1);
        chk("ga_state", state, 3'd0);
        chk("ga_timer", timer, 4'd1);
        chk("ga_la", light_a, 3'b001);
        chk("ga_lb", light_b, 3'b100);
        cyc(23);
        chk("ga_max_state", state, 3'd0);
        chk("ga_max_timer", timer, 4'd6);
        chk("ga_max_tick", tick, 1'b1);
        cyc(1);
        chk("ya_state", state, 3'd1);
        chk("ya_timer", timer, 4'd1);
        chk("ya_la", light_a, 3'b010);
        cyc(8);
        chk("ra_state", state, 3'd2);
        chk("ra_timer", timer, 4'd1);
        chk("ra_la", light_a, 3'b100);
        cyc(4);
        chk("gb_state", state, 3'd3);
        chk("gb_la", light_a, 3'b100);
        chk("gb_lb", light_b, 3'b001);
        cyc(16);
        chk("yb_state", state, 3'd4);
        chk("yb_lb", light_b, 3'b010);
        cyc(8);
        chk("rb_state", state, 3'd5);
        cyc(4);
        chk("ga2_state", state, 3'd0);
        chk("ga2_timer", timer, 4'd1);

        // 2. early exit on latched road B request
        req_b = 1'b1;
        cyc(1);
        req_b = 1'b0;
        cyc(7);
        chk("ee_hold_state", state, 3'd0);
        chk("ee_hold_timer", timer, 4'd3);
        cyc(1);
        chk("ee_exit_state", state, 3'd1);
        chk("ee_exit_timer", timer, 4'd1);
        cyc(7);
        chk("ee_ra_state", state, 3'd2);
        chk("ee_pend_b_held", u_dut.pend_b_r, 1'b1);
        cyc(4);
        chk("ee_gb_state", state, 3'd3);
        chk("ee_pend_b_clr", u_dut.pend_b_r, 1'b0);
        cyc(28);
        chk("ee_ga_state", state, 3'd0);

        // 3. contention: req_a held on the green road blocks early exit
        req_a = 1'b1;
        req_b = 1'b1;
        cyc(1);
        req_b = 1'b0;
        cyc(7);
        chk("ct_t3_state", state, 3'd0);
        chk("ct_t3_timer", timer, 4'd3);
        cyc(4);
        chk("ct_t4_state", state, 3'd0);
        chk("ct_t4_timer", timer, 4'd4);
        chk("ct_pend_a", u_dut.pend_a_r, 1'b0);
        req_a = 1'b0;
        cyc(1);
        chk("ct_exit_state", state, 3'd1);
        cyc(7);
        chk("ct_ra_state", state, 3'd2);
        cyc(4);
        chk("ct_gb_state", state, 3'd3);

        // 4. flash requested during GREEN_B
        flash = 1'b1;
        cyc(16);
        chk("fl_yb_state", state, 3'd4);
        cyc(8);
        chk("fl_rb_state", state, 3'd5);
        cyc(4);
        chk("fl_state", state, 3'd6);
        chk("fl_timer", timer, 4'd1);
        chk("fl_on_la", light_a, 3'b010);
        chk("fl_on_lb", light_b, 3'b100);
        cyc(4);
        chk("fl_off_la", light_a, 3'b000);
        chk("fl_off_lb", light_b, 3'b000);
        chk("fl_off_state", state, 3'd6);
        cyc(4);
        chk("fl_on2_la", light_a, 3'b010);
        chk("fl_on2_lb", light_b, 3'b100);
        chk("fl_timer3", timer, 4'd3);
        flash = 1'b0;
        cyc(4);
        chk("fl_exit_state", state, 3'd5);
        chk("fl_exit_timer", timer, 4'd1);
        cyc(4);
        chk("fl_ga_state", state, 3'd0);

        // 5. reset mid-operation in YELLOW_A with pend_b set
        req_b = 1'b1;
        cyc(1);
        req_b = 1'b0;
        cyc(8);
        chk("mr_ya_state", state, 3'd1);
        chk("mr_pend_b", u_dut.pend_b_r, 1'b1);
        cyc(1);
        chk("mr_presc", u_dut.presc_r, 2'd2);
        reset = 1'b1;
        cyc(1);
        chk("mr_state", state, 3'd5);
        chk("mr_timer", timer, 4'd1);
        chk("mr_pend_b_clr", u_dut.pend_b_r, 1'b0);
        chk("mr_tick", tick, 1'b0);
        chk("mr_la", light_a, 3'b100);
        reset = 1'b0;
        cyc(2);
        chk("mr_no_tick", tick, 1'b0);
        cyc(1);
        chk("mr_tick_on", tick, 1'b1);
        cyc(1);
        chk("mr_ga_state", state, 3'd0);

        // 6a. illegal state code recovers to RED_B
        force u_dut.state_r = 3'd7;
        #1;
        chk("il_forced", state, 3'd7);
        @(posedge clk);
        #1;
        release u_dut.state_r;
        begin
            int waited;
            waited = 0;
            while ((state !== 3'd5) && (waited < 3)) begin
                @(negedge clk);
                waited++;
            end
            chk("il_recover_state", state, 3'd5);
            chk("il_recover_timer", timer, 4'd1);
        end

        // 6b. timer saturation with a 2-bit timer held in FLASH
        reset2 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            chk("sat_nonzero", (timer2 != 2'd0), 1'b1);
        end
        chk("sat_state", state2, 3'd6);
        chk("sat_timer", timer2, 2'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
